// File: rtl/ppu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ppu_pkg
// Purpose : Shared types for the posit processing unit. Holds the posit word
//           type, the operation encoding, the operand-stage state encoding
//           and the two's-complement helper used on posit operands.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package ppu_pkg;

  localparam int unsigned C_POSIT_N = 16;

  typedef logic [C_POSIT_N-1:0] posit_t;

  // ADD is encoded as 0 so that cleared storage reads back as ADD.
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } operation_e;

  // Encoded so that the state value is the number of buffered entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Two's complement on a wide word. The low bits of the result are the
  // correct negation for any narrower posit width, so callers zero-extend,
  // negate and truncate. Zero and NaR map onto themselves.
  function automatic logic [63:0] c2(input logic [63:0] x);
    return (~x) + 64'd1;
  endfunction

endpackage : ppu_pkg
`default_nettype wire

// File: rtl/operand_register_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : operand_register_stage
// Purpose : Two-entry elastic buffer between the operand source and
//           input_conditioning. Fully registered toward both sides: ready
//           and valid depend only on stored state, and output data is read
//           from storage, so no input reaches an output combinationally.
//
// Optional feature (macro INPUT_STAGE_SUB_TO_ADD_EN):
//   when defined, SUB entries are stored as ADD with p2 negated at push time.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   flush_i      : synchronous discard of all buffered entries
//   in_valid_i   : upstream operand set valid
//   in_ready_o   : stage can accept (state != FULL)
//   p1_i..p3_i   : posit operands, N bits each
//   op_i         : requested operation
//   out_valid_o  : head entry valid (state != EMPTY)
//   out_ready_i  : downstream accepts
//   p1_o..p3_o   : head entry operands
//   op_o         : head entry operation
//   occupancy_o  : number of buffered entries, 0..2
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module operand_register_stage
  import ppu_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 2   // only 2 is supported; pointers are 1 bit
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] p1_i,
  input  logic [N-1:0] p2_i,
  input  logic [N-1:0] p3_i,
  input  operation_e   op_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] p1_o,
  output logic [N-1:0] p2_o,
  output logic [N-1:0] p3_o,
  output operation_e   op_o,
  output logic [1:0]   occupancy_o
);

  stage_state_e r_state;
  logic         r_wptr;
  logic         r_rptr;
  logic [N-1:0] r_p1 [DEPTH];
  logic [N-1:0] r_p2 [DEPTH];
  logic [N-1:0] r_p3 [DEPTH];
  operation_e   r_op [DEPTH];

  logic         w_push;
  logic         w_pop;
  logic [N-1:0] w_p2_store;
  operation_e   w_op_store;

  // Handshakes use only registered state for ready/valid.
  assign w_push = in_valid_i && (r_state != FULL);
  assign w_pop  = out_ready_i && (r_state != EMPTY);

`ifdef INPUT_STAGE_SUB_TO_ADD_EN
  logic w_is_sub;
  assign w_is_sub   = (op_i == SUB);
  assign w_op_store = w_is_sub ? ADD : op_i;
  assign w_p2_store = w_is_sub ? N'(c2(64'(p2_i))) : p2_i;
`else
  assign w_op_store = op_i;
  assign w_p2_store = p2_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_p1[i] <= '0;
        r_p2[i] <= '0;
        r_p3[i] <= '0;
        r_op[i] <= ADD;
      end
    end else if (flush_i) begin
      // Flush wins over any same-cycle push or pop; storage contents are
      // left as-is since nothing is valid afterwards.
      r_state <= EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_p1[r_wptr] <= p1_i;
        r_p2[r_wptr] <= w_p2_store;
        r_p3[r_wptr] <= p3_i;
        r_op[r_wptr] <= w_op_store;
        r_wptr       <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case (r_state)
        EMPTY:   if (w_push) r_state <= ONE;
        ONE: begin
          if (w_push && !w_pop)      r_state <= FULL;
          else if (!w_push && w_pop) r_state <= EMPTY;
        end
        FULL:    if (w_pop) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign in_ready_o  = (r_state != FULL);
  assign out_valid_o = (r_state != EMPTY);
  assign occupancy_o = r_state;

  assign p1_o = r_p1[r_rptr];
  assign p2_o = r_p2[r_rptr];
  assign p3_o = r_p3[r_rptr];
  assign op_o = r_op[r_rptr];

endmodule : operand_register_stage
`default_nettype wire

// File: tb/tb_operand_register_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_operand_register_stage
// Purpose : Directed self-checking bench for operand_register_stage (N=16).
//           Observed outputs are packed as
//           {out_valid, in_ready, occupancy, p1, p2, p3, op}.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_operand_register_stage;
  import ppu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p1, p2, p3;
  operation_e  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p1_o, p2_o, p3_o;
  operation_e  op_o;
  logic [1:0]  occ;

  int vectors = 0;
  int errors  = 0;

  logic [53:0] obs, expv;
  logic [3:0]  obs_c, exp_c;

  operand_register_stage #(.N(16), .DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .p1_i(p1), .p2_i(p2), .p3_i(p3), .op_i(op),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .p1_o(p1_o), .p2_o(p2_o), .p3_o(p3_o), .op_o(op_o),
    .occupancy_o(occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input operation_e o);
    in_valid = v; p1 = a; p2 = b; p3 = c; op = o;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    #1;
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b0, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0, ADD};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, expv); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive(1'b1, 16'h4000, 16'h3000, 16'h0000, ADD);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h4000, 16'h3000, 16'h0000, ADD};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL latency_push: got %h expected %h", obs, expv); end
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
    obs_c = {out_valid, in_ready, occ}; exp_c = {1'b0, 1'b1, 2'd0};
    vectors++;
    if (obs_c !== exp_c) begin errors++; $display("FAIL latency_drain: got %h expected %h", obs_c, exp_c); end
  endtask

  // Also covers FULL with simultaneous push and pop: the push is ignored.
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h2222, 16'h3333, MUL);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h1111, 16'h2222, 16'h3333, MUL};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL bp_push_a: got %h expected %h", obs, expv); end
    drive(1'b1, 16'h4444, 16'h5555, 16'h6666, DIV);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b0, 2'd2, 16'h1111, 16'h2222, 16'h3333, MUL};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL bp_full: got %h expected %h", obs, expv); end
    drive(1'b1, 16'h7777, 16'h8888, 16'h9999, ADD);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL bp_hold: got %h expected %h", obs, expv); end
    out_ready = 1'b1;
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h4444, 16'h5555, 16'h6666, DIV};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL bp_full_pop_push: got %h expected %h", obs, expv); end
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h7777, 16'h8888, 16'h9999, ADD};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL bp_head_c: got %h expected %h", obs, expv); end
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
    obs_c = {out_valid, in_ready, occ}; exp_c = {1'b0, 1'b1, 2'd0};
    vectors++;
    if (obs_c !== exp_c) begin errors++; $display("FAIL bp_drain: got %h expected %h", obs_c, exp_c); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    drive(1'b1, 16'haaaa, 16'hbbbb, 16'hcccc, MUL);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 16'hdddd, 16'heeee, 16'hffff, DIV);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'hdddd, 16'heeee, 16'hffff, DIV};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sim_one_push_pop: got %h expected %h", obs, expv); end
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
    obs_c = {out_valid, in_ready, occ}; exp_c = {1'b0, 1'b1, 2'd0};
    vectors++;
    if (obs_c !== exp_c) begin errors++; $display("FAIL sim_drain: got %h expected %h", obs_c, exp_c); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 16'h0202, 16'h0303, MUL);
    tick();
    drive(1'b1, 16'h0404, 16'h0505, 16'h0606, DIV);
    tick();
    obs_c = {out_valid, in_ready, occ}; exp_c = {1'b1, 1'b0, 2'd2};
    vectors++;
    if (obs_c !== exp_c) begin errors++; $display("FAIL flush_prefill: got %h expected %h", obs_c, exp_c); end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 16'h0bad, 16'h0bad, 16'h0bad, MUL);
    tick();
    obs_c = {out_valid, in_ready, occ}; exp_c = {1'b0, 1'b1, 2'd0};
    vectors++;
    if (obs_c !== exp_c) begin errors++; $display("FAIL flush_empty: got %h expected %h", obs_c, exp_c); end
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
    obs_c = {out_valid, in_ready, occ};
    vectors++;
    if (obs_c !== exp_c) begin errors++; $display("FAIL flush_no_ghost: got %h expected %h", obs_c, exp_c); end
    out_ready = 1'b0;
    drive(1'b1, 16'h0e0e, 16'h0f0f, 16'h1010, MUL);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h0e0e, 16'h0f0f, 16'h1010, MUL};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL flush_refill: got %h expected %h", obs, expv); end
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 16'h1357, 16'h2468, 16'h3579, MUL);
    tick();
    drive(1'b1, 16'h4680, 16'h5791, 16'h6802, DIV);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    #2;
    rst = 1'b1;
    #1;
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b0, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0, ADD};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, expv); end
    #1;
    rst = 1'b0;
    drive(1'b1, 16'h5a5a, 16'ha5a5, 16'h0f0f, MUL);
    tick();
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h5a5a, 16'ha5a5, 16'h0f0f, MUL};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL reset_first_push: got %h expected %h", obs, expv); end
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
  endtask

  task automatic test_sub_to_add();
    logic [15:0] e_p2;
    operation_e  e_op;
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 16'h4000, 16'h0000, SUB);
    tick();
`ifdef INPUT_STAGE_SUB_TO_ADD_EN
    e_p2 = 16'hc000; e_op = ADD;
`else
    e_p2 = 16'h4000; e_op = SUB;
`endif
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    expv = {1'b1, 1'b1, 2'd1, 16'h1234, e_p2, 16'h0000, e_op};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sub_p2_4000: got %h expected %h", obs, expv); end
    out_ready = 1'b1;
    drive(1'b1, 16'h0001, 16'h8000, 16'h0002, SUB);
    tick();
    expv = {1'b1, 1'b1, 2'd1, 16'h0001, 16'h8000, 16'h0002, e_op};
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sub_p2_nar: got %h expected %h", obs, expv); end
    drive(1'b1, 16'h0003, 16'h0001, 16'h0004, SUB);
    tick();
`ifdef INPUT_STAGE_SUB_TO_ADD_EN
    e_p2 = 16'hffff;
`else
    e_p2 = 16'h0001;
`endif
    expv = {1'b1, 1'b1, 2'd1, 16'h0003, e_p2, 16'h0004, e_op};
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sub_p2_one: got %h expected %h", obs, expv); end
    drive(1'b1, 16'h0005, 16'h0000, 16'h0006, SUB);
    tick();
    expv = {1'b1, 1'b1, 2'd1, 16'h0005, 16'h0000, 16'h0006, e_op};
    obs  = {out_valid, in_ready, occ, p1_o, p2_o, p3_o, op_o};
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sub_p2_zero: got %h expected %h", obs, expv); end
    drive(1'b0, 16'h0, 16'h0, 16'h0, ADD);
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_sub_to_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_operand_register_stage
`default_nettype wire
